c2_rx_buffer: RTL

// - Elastic byte FIFO between uart_transceiver RX outputs and the C2 arbiter/loader/debug RX path.
// - Absorbs RX bytes arriving while consumers are busy (e.g. the loader during memory writes).
// - Replays buffered bytes as one-cycle data/strobe pairs, the same contract as uart_transceiver RX.
// - Reports fill level, a sticky overflow flag and a sticky framing-error flag.

---
 rtl/c2_rx_buffer_if.sv | 30 +++
 rtl/c2_rx_buffer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/c2_rx_buffer_if.sv
// Bus bundle for c2_rx_buffer: RX byte input, flow control, emitted byte and status.
// Signal names carry the buffer's point of view (_i into the buffer, _o out of it).
interface c2_rx_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          hold_i;
  logic [7:0]    in_data_i;
  logic          in_valid_i;
  logic          in_error_i;
  logic [7:0]    out_data_o;
  logic          out_ready_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          frame_err_o;

  // The buffer itself.
  modport slave (
    input  flush_i, hold_i, in_data_i, in_valid_i, in_error_i,
    output out_data_o, out_ready_o, level_o, overflow_o, frame_err_o
  );

  // The side that feeds bytes in and consumes the replayed strobes.
  modport master (
    output flush_i, hold_i, in_data_i, in_valid_i, in_error_i,
    input  out_data_o, out_ready_o, level_o, overflow_o, frame_err_o
  );
endinterface

// File: rtl/c2_rx_buffer.sv
// Elastic byte FIFO between the UART RX strobe and the C2 consumers.
// Buffered bytes are replayed as registered one-cycle data/strobe pairs,
// spaced at least MIN_GAP cycles apart, and paused while hold_i is high.
module c2_rx_buffer #(
  parameter int DEPTH   = 16,
  parameter int MIN_GAP = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  c2_rx_buffer_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [7:0]    mem [DEPTH];

  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [LW-1:0] level_q,     level_d;
  logic [GW-1:0] gap_q,       gap_d;
  logic [7:0]    out_data_q,  out_data_d;
  logic          out_ready_q, out_ready_d;
  logic          overflow_q,  overflow_d;
  logic          frame_err_q, frame_err_d;

  logic full, empty, pop, push, good_byte;

  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);
  assign good_byte = bus.in_valid_i && !bus.in_error_i;
  // An emission frees a slot in the same edge, so a full FIFO still accepts a byte then.
  assign pop       = !empty && !bus.hold_i && (gap_q == '0) && !bus.flush_i;
  assign push      = good_byte && (!full || pop) && !bus.flush_i;

  // Next-state computation for pointers, level, pacing counter, output byte and sticky flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    gap_d       = gap_q;
    out_data_d  = out_data_q;
    out_ready_d = 1'b0;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;

    if (bus.flush_i) begin
      // Flush drops everything queued but leaves the last emitted byte visible.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      gap_d       = '0;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        out_data_d  = mem[rd_ptr_q];
        out_ready_d = 1'b1;
        gap_d       = GAP_RELOAD;
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (good_byte && full && !pop) begin
        overflow_d = 1'b1;
      end
      if (bus.in_error_i) begin
        frame_err_d = 1'b1;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_ready_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      gap_q       <= gap_d;
      out_data_q  <= out_data_d;
      out_ready_q <= out_ready_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the array is deliberately not reset; level_q gates every read, so stale
    // contents are never emitted and the array can map onto plain RAM.
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data_i;
    end
  end

  assign bus.out_data_o  = out_data_q;
  assign bus.out_ready_o = out_ready_q;
  assign bus.level_o     = level_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.frame_err_o = frame_err_q;

endmodule
